encoder_position_tracker: RTL
=============================

Name: encoder_position_tracker

Overview:
Downstream consumer of the quadrature direction decoder's per-clock dir code (01 = CCW step, 10 = CW step, 00 = none).
- Accumulates a signed absolute position with wrap or saturate policy.
- Supports synchronous clear and preset.
- Measures velocity as the net step count per fixed window and hands each sample to the control logic over a valid/ready interface.

Parameters:
POS_W, 16, position width (signed two's complement)
VEL_W, 8, velocity sample width (signed)
WINDOW_CYCLES, 50000, clk cycles per velocity window (>=2)
SATURATE, 0, 0 = position wraps; 1 = position clamps at signed min/max

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
dir  in  2  step code from direction decoder: 01 = +1, 10 = -1, 00 = none, 11 = illegal
clear  in  1  sync clear of position, velocity path and flags
preset_en  in  1  sync load of position from preset_val
preset_val  in  POS_W  value loaded on preset_en
position  out  POS_W  signed accumulated position
limit_hit  out  1  sticky; SATURATE=1: clamp occurred; SATURATE=0: wrap occurred
dir_err  out  1  one-cycle pulse when dir==11 is sampled
velocity  out  VEL_W  signed net steps in last completed window
vel_valid  out  1  velocity sample pending
vel_ready  in  1  consumer accepts sample
vel_overrun  out  1  sticky; a pending sample was overwritten

Behaviour:
- Reset (rst_n low, async): position=0, velocity=0, vel_valid=0, limit_hit=0, vel_overrun=0, dir_err=0. Window counter=0, accumulator=0.
- Step decode: dir sampled every rising edge. step = +1 / -1 / 0. dir==11 gives step=0 and dir_err=1 for the following cycle only.
- Position latency: new value is registered on the same edge dir is sampled, so it is visible one cycle after dir presented.
- Position priority per edge: clear > preset_en > step.
  - clear: position=0.
  - preset_en: position=preset_val; the step that cycle is dropped.
- Wrap (SATURATE=0): 2^(POS_W-1)-1 +1 -> -2^(POS_W-1), and the reverse; sets limit_hit.
- Saturate (SATURATE=1): position holds at max/min and sets limit_hit when a step would exceed range.
- Window timer: counts 0..WINDOW_CYCLES-1 and wraps. Terminal count = cycle where count==WINDOW_CYCLES-1.
- Accumulator:
  - Signed VEL_W; adds every step, including steps on preset cycles.
  - Saturates at VEL_W signed limits and never wraps.
- On terminal cycle:
  - velocity <= saturate(acc + step).
  - acc <= 0.
  - vel_valid <= 1.
- Handshake, two states:
  - IDLE (vel_valid=0) -> PEND on terminal.
  - PEND -> IDLE on vel_ready with no terminal that cycle.
  - PEND plus terminal, vel_ready=1: stays PEND with new sample, no overrun.
  - PEND plus terminal, vel_ready=0: sample overwritten, vel_overrun=1.
  - velocity is stable while vel_valid=1 and no terminal occurs.
- clear also resets acc, window counter, velocity, vel_valid, limit_hit, vel_overrun. It takes priority over terminal.
- Reset mid-window discards the partial accumulation. No sample is emitted.

Decomposition:
- Shared package encoder_pkg:
  - DIR_NONE=2'b00, DIR_CCW=2'b01, DIR_CW=2'b10, DIR_ILLEGAL=2'b11.
  - Handshake state enum {VEL_IDLE, VEL_PEND}.
  - Also used by the direction decoder.
- One sub-module: encoder_window_timer.
  - Parameter WINDOW_CYCLES; inputs clk, rst_n, clear; output tick.
  - Reused by future period/RPM blocks.

Test Plan (POS_W=8, VEL_W=4, WINDOW_CYCLES=8 unless noted):
1. Reset, then 5 cycles dir=01 followed by 3 cycles dir=10 -> position reads 1, 2, 3, 4, 5, 4, 3, 2; dir_err stays 0.
2. preset_en with preset_val=127 plus one dir=01, SATURATE=0 -> position=-128, limit_hit=1. Same with SATURATE=1 -> position stays 127, limit_hit=1.
3. 8-cycle window with 6x dir=01 and 1x dir=10, vel_ready=1 -> velocity=5, vel_valid high exactly 1 cycle.
4. vel_ready=0 for 2 windows (3 then 4 net steps) -> velocity=3, then 4; vel_overrun=1; valid held until vel_ready=1, then drops.
5. 10 steps dir=01 in one window (WINDOW_CYCLES=12) -> velocity=7 (VEL_W saturation); position=10.
6. dir=11 one cycle, then clear together with dir=01 -> dir_err one-cycle pulse, position=0, vel_valid=0, flags cleared; async rst_n mid-window -> all outputs 0 without waiting for a clock edge.

Source files
------------

// File: rtl/encoder_pkg.sv
// encoder_pkg: shared quadrature step codes and velocity handshake states.
// Contents: DIR_* step codes from the direction decoder, vel_state_e handshake states.
package encoder_pkg;
  localparam logic [1:0] DIR_NONE    = 2'b00;
  localparam logic [1:0] DIR_CCW     = 2'b01;
  localparam logic [1:0] DIR_CW      = 2'b10;
  localparam logic [1:0] DIR_ILLEGAL = 2'b11;
  typedef enum logic {VEL_IDLE, VEL_PEND} vel_state_e;
endpackage

// File: rtl/encoder_window_timer.sv
// encoder_window_timer: free-running 0..WINDOW_CYCLES-1 counter with terminal-count tick.
// Ports: clk, rst_n (async active-low), clear (sync restart), tick (high on the last cycle of each window).
module encoder_window_timer #(
  parameter int WINDOW_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic tick
);
  localparam int CW = $clog2(WINDOW_CYCLES);
  logic [CW-1:0] count;
  assign tick = count == CW'(WINDOW_CYCLES - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) count <= '0;
    else count <= (clear || tick) ? '0 : count + 1'b1;
endmodule

// File: rtl/encoder_position_tracker.sv
// encoder_position_tracker: position accumulator and windowed velocity sampler for quadrature step codes.
// Ports: clk, rst_n (async active-low), dir (step code), clear / preset_en / preset_val (sync position control),
//        position, limit_hit (sticky wrap/clamp), dir_err (illegal-code pulse),
//        velocity / vel_valid / vel_ready (sample handshake), vel_overrun (sticky overwritten sample).
module encoder_position_tracker
  import encoder_pkg::*;
#(
  parameter int POS_W         = 16,
  parameter int VEL_W         = 8,
  parameter int WINDOW_CYCLES = 50000,
  parameter int SATURATE      = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       dir,
  input  logic             clear,
  input  logic             preset_en,
  input  logic [POS_W-1:0] preset_val,
  output logic [POS_W-1:0] position,
  output logic             limit_hit,
  output logic             dir_err,
  output logic [VEL_W-1:0] velocity,
  output logic             vel_valid,
  input  logic             vel_ready,
  output logic             vel_overrun
);
  localparam logic [POS_W-1:0] POS_MAX = {1'b0, {(POS_W-1){1'b1}}};
  localparam logic [POS_W-1:0] POS_MIN = {1'b1, {(POS_W-1){1'b0}}};
  logic up, dn, tick, pos_ovf;
  logic [VEL_W-1:0] acc, acc_next;
  logic [VEL_W:0] sum;
  vel_state_e state, state_next;
  assign up = dir == DIR_CCW;
  assign dn = dir == DIR_CW;
  assign pos_ovf = (up && position == POS_MAX) || (dn && position == POS_MIN);
  // {dn..dn, up|dn} is +1, -1 (all ones) or 0 at any width
  assign sum = {acc[VEL_W-1], acc} + {{VEL_W{dn}}, up | dn};
  // a sign mismatch in the extra bit means the add left the VEL_W range: clamp toward the sign of the sum
  assign acc_next = (sum[VEL_W] != sum[VEL_W-1]) ? {sum[VEL_W], {(VEL_W-1){~sum[VEL_W]}}} : sum[VEL_W-1:0];
  assign vel_valid = state == VEL_PEND;
  encoder_window_timer #(.WINDOW_CYCLES(WINDOW_CYCLES)) u_timer (
    .clk(clk),
    .rst_n(rst_n),
    .clear(clear),
    .tick(tick)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= VEL_IDLE;
    else state <= state_next;
  always_comb begin
    state_next = state;
    if (clear) state_next = VEL_IDLE;
    else if (tick) state_next = VEL_PEND;
    else if (vel_ready) state_next = VEL_IDLE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      position    <= '0;
      limit_hit   <= 1'b0;
      dir_err     <= 1'b0;
      velocity    <= '0;
      acc         <= '0;
      vel_overrun <= 1'b0;
    end else begin
      dir_err <= dir == DIR_ILLEGAL;
      if (clear) begin
        position    <= '0;
        limit_hit   <= 1'b0;
        velocity    <= '0;
        acc         <= '0;
        vel_overrun <= 1'b0;
      end else begin
        position    <= preset_en ? preset_val
                     : (pos_ovf && SATURATE != 0) ? position
                     : position + {{(POS_W-1){dn}}, up | dn};
        limit_hit   <= limit_hit | (!preset_en && pos_ovf);
        acc         <= tick ? '0 : acc_next;
        velocity    <= tick ? acc_next : velocity;
        vel_overrun <= vel_overrun | (tick && vel_valid && !vel_ready);
      end
    end
endmodule
